spi_mem_ctrl: RTL and testbench
===============================

// Module: spi_mem_ctrl
// PURPOSE
//  Transaction sequencer between the SPI slave byte interface and the register-file memory in memory_top.
//  - Decodes the 8-bit command frame {rsvd[7:5], addr[4:1], rw[0]}; rw=1 write, rw=0 read.
//  - Assembles write data from following frames, LSB byte first; serialises read data back into the SPI TX byte.
//  - State persists across ss_n toggles; frames may each use their own ss_n assertion.
// PARAMETERS
//  FRAME_SIZE      8     bits per SPI frame
//  DATA_WIDTH      32    memory word width; DATA_BYTES = DATA_WIDTH/FRAME_SIZE (must divide exactly)
//  ADDR_WIDTH      4     memory address width (command bits [ADDR_WIDTH:1])
//  TIMEOUT_CYCLES  1024  idle clk cycles between frames before abort (SPI_MEM_TIMEOUT_EN only)
// PORTS
//  clk        in   1           system clock, all logic on posedge
//  reset_n    in   1           asynchronous active-low reset
//  rx_valid   in   1           1-cycle pulse: frame received from SPI slave
//  rx_data    in   FRAME_SIZE  received frame, valid with rx_valid
//  tx_load    out  1           1-cycle pulse: SPI slave loads tx_data as next MISO frame
//  tx_data    out  FRAME_SIZE  next frame to shift out
//  mem_we     out  1           1-cycle write strobe
//  mem_re     out  1           1-cycle read strobe
//  mem_addr   out  ADDR_WIDTH  memory address
//  mem_wdata  out  DATA_WIDTH  write data
//  mem_rdata  in   DATA_WIDTH  read data, valid cycle after mem_re
//  busy       out  1           high whenever state != IDLE
//  err        out  1           1-cycle pulse on overrun or timeout
// BEHAVIOUR
//  Reset: state=IDLE, byte_cnt=0, all outputs 0, data/addr registers 0.
//  FSM (all transitions on posedge clk):
//   IDLE: rx_valid -> latch addr=rx_data[ADDR_WIDTH:1]; rw=1 -> WDATA, rw=0 -> RD_REQ; byte_cnt=0. rsvd bits ignored.
//   WDATA: each rx_valid writes rx_data into mem_wdata byte[byte_cnt], byte_cnt++; on byte DATA_BYTES-1 -> COMMIT.
//   COMMIT: mem_we=1 for exactly one cycle with mem_addr/mem_wdata stable -> IDLE.
//   RD_REQ: mem_re=1 one cycle -> RD_WAIT.
//   RD_WAIT: capture mem_rdata into rbuf; tx_data=rbuf[7:0], tx_load=1 -> RDATA, byte_cnt=0.
//   RDATA: each rx_valid (dummy frame, previous TX byte shifted) byte_cnt++; if byte_cnt<DATA_BYTES
//          tx_data=rbuf byte[byte_cnt], tx_load pulse same cycle; after DATA_BYTES frames -> IDLE.
//  Latency: command frame -> mem_re 1 cycle; rx_valid of last write byte -> mem_we 1 cycle; mem_re -> tx_load 1 cycle.
//  Overrun: rx_valid in COMMIT, RD_REQ or RD_WAIT -> frame dropped, err pulse, FSM continues unaffected.
//  Address: ADDR_WIDTH bits taken directly, no wrap arithmetic; addr 15 valid.
//  mem_addr/mem_wdata hold last value in IDLE; tx_data holds until next tx_load.
//  Reset mid-transaction: immediate return to IDLE, partial write discarded, no mem_we.
// CONFIGURATION
//  SPI_MEM_TIMEOUT_EN defined: counter clears on every rx_valid and in IDLE; in WDATA or RDATA,
//   TIMEOUT_CYCLES cycles without rx_valid -> IDLE, err pulse, no mem_we, byte_cnt=0.
//  Undefined: no counter; FSM waits indefinitely for frames; only reset aborts.
// TESTING
//  1 Write: frames 0x07,0x07,0x1E,0xC3,0xA5 -> single mem_we, mem_addr=3, mem_wdata=0xA5C31E07, err=0.
//  2 Read: frame 0x06, mem_rdata=0xA5C31E07 -> mem_re addr 3; tx_load tx_data=0x07; 3 dummy frames -> 0x1E,0xC3,0xA5; 4th frame -> busy=0.
//  3 Overrun: force rx_valid in the COMMIT cycle of test 1 -> err pulse, write still 0xA5C31E07, next frame decoded as command.
//  4 Timeout (macro on): frame 0x0F then none for 1024 cycles -> err pulse, busy=0, no mem_we; macro off -> busy stays 1.
//  5 Reset mid-write: 0x07,0x11,0x22 then reset_n low 2 cycles -> outputs 0; then 0x06 -> mem_re addr 3, no mem_we ever.
//  6 Top address: write 0x1F + 0xDEADBEEF bytes, read 0x1E -> mem_addr=15 both, TX bytes 0xEF,0xBE,0xAD,0xDE.

Source files
------------

// File: rtl/spi_mem_ctrl.sv
// SPI frame <-> register-file transaction sequencer: command decode, write assembly, read serialisation.
// Optional inter-frame idle abort is built when SPI_MEM_TIMEOUT_EN is defined.
module spi_mem_ctrl #(
  parameter int FRAME_SIZE     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_valid,
  input  logic [FRAME_SIZE-1:0] rx_data,
  output logic                  tx_load,
  output logic [FRAME_SIZE-1:0] tx_data,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  err
);

  localparam int DATA_BYTES = DATA_WIDTH / FRAME_SIZE;
  localparam int CNT_W      = $clog2(DATA_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WDATA   = 3'd1,
    COMMIT  = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    RDATA   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d, byte_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rbuf_q, rbuf_d;
  logic [FRAME_SIZE-1:0]   tx_data_q, tx_data_d;
  logic                    err_q, overrun, tmo_hit;

  assign byte_cnt_nxt = byte_cnt_q + 1'b1;

`ifdef SPI_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             waiting;

  assign waiting = (state_q == WDATA) || (state_q == RDATA);
  assign tmo_hit = waiting && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 tmo_q <= '0;
    else if (rx_valid || !waiting) tmo_q <= '0;
    else                          tmo_q <= tmo_q + 1'b1;
  end
`else
  wire unused_tmo = (TIMEOUT_CYCLES > 0);
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    tx_data_d  = tx_data_q;
    tx_load    = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    overrun    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          addr_d     = rx_data[ADDR_WIDTH:1];
          byte_cnt_d = '0;
          state_d    = rx_data[0] ? WDATA : RD_REQ;
        end
      end
      WDATA: begin
        if (rx_valid) begin
          for (int i = 0; i < DATA_BYTES; i++)
            if (byte_cnt_q == CNT_W'(i)) wdata_d[i*FRAME_SIZE +: FRAME_SIZE] = rx_data;
          byte_cnt_d = byte_cnt_nxt;
          if (byte_cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = COMMIT;
          end
        end else if (tmo_hit) begin
          byte_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      COMMIT: begin
        mem_we  = 1'b1;
        overrun = rx_valid;
        state_d = IDLE;
      end
      RD_REQ: begin
        mem_re  = 1'b1;
        overrun = rx_valid;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Read data is only valid this cycle, so it feeds tx_data directly while rbuf captures it.
        overrun    = rx_valid;
        rbuf_d     = mem_rdata;
        tx_data_d  = mem_rdata[FRAME_SIZE-1:0];
        tx_load    = 1'b1;
        byte_cnt_d = '0;
        state_d    = RDATA;
      end
      RDATA: begin
        if (rx_valid) begin
          if (byte_cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_nxt;
            tx_load    = 1'b1;
            for (int i = 0; i < DATA_BYTES; i++)
              if (byte_cnt_nxt == CNT_W'(i)) tx_data_d = rbuf_q[i*FRAME_SIZE +: FRAME_SIZE];
          end
        end else if (tmo_hit) begin
          byte_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        byte_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      tx_data_q  <= tx_data_d;
      err_q      <= overrun | tmo_hit;
    end
  end

  assign tx_data   = tx_data_d;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with queue scoreboards for memory writes, reads and TX bytes.
module tb_spi_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset_n, rx_valid, tx_load, mem_we, mem_re, busy, err;
  logic [7:0]  rx_data, tx_data;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int errors = 0, checks = 0, err_pulses = 0;
  logic [35:0] wq[$];
  logic [3:0]  rq[$];
  logic [7:0]  tq[$];

  always #5 clk = ~clk;

  spi_mem_ctrl dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_load(tx_load), .tx_data(tx_data), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pops on every DUT strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (err === 1'b1) err_pulses++;
    if (mem_we !== 1'b0) begin
      if (wq.size() == 0) check("we_unexpected", {35'b0, mem_we}, 36'h0);
      else                check("write", {mem_addr, mem_wdata}, wq.pop_front());
    end
    if (mem_re !== 1'b0) begin
      if (rq.size() == 0) check("re_unexpected", {35'b0, mem_re}, 36'h0);
      else                check("read_addr", {32'b0, mem_addr}, {32'b0, rq.pop_front()});
    end
    if (tx_load !== 1'b0) begin
      if (tq.size() == 0) check("tx_unexpected", {35'b0, tx_load}, 36'h0);
      else                check("tx_byte", {28'b0, tx_data}, {28'b0, tq.pop_front()});
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic expect_read(input logic [3:0] a, input logic [31:0] d);
    mem_rdata = d;
    rq.push_back(a);
    for (int i = 0; i < 4; i++) tq.push_back(d[i*8 +: 8]);
  endtask

  task automatic dummies(input int n);
    for (int i = 0; i < n; i++) send(8'h00, 2);
  endtask

  initial begin
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; mem_rdata = 32'h0;
    repeat (3) @(posedge clk); #1;
    check("rst_tx_load", {35'b0, tx_load}, 36'h0);
    check("rst_tx_data", {28'b0, tx_data}, 36'h0);
    check("rst_mem_we", {35'b0, mem_we}, 36'h0);
    check("rst_mem_re", {35'b0, mem_re}, 36'h0);
    check("rst_mem_addr", {32'b0, mem_addr}, 36'h0);
    check("rst_mem_wdata", {4'b0, mem_wdata}, 36'h0);
    check("rst_busy", {35'b0, busy}, 36'h0);
    check("rst_err", {35'b0, err}, 36'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write A5C31E07 to address 3
    wq.push_back({4'd3, 32'hA5C31E07});
    send(8'h07, 2); send(8'h07, 2); send(8'h1E, 2); send(8'hC3, 2);
    send(8'hA5, 0);
    check("we_latency", {35'b0, mem_we}, 36'h1);
    repeat (3) @(posedge clk); #1;
    check("t1_busy", {35'b0, busy}, 36'h0);
    check("t1_err", err_pulses, 36'h0);

    // Read back address 3
    expect_read(4'd3, 32'hA5C31E07);
    send(8'h06, 0);
    check("re_latency", {35'b0, mem_re}, 36'h1);
    @(posedge clk); #1;
    check("tx_latency", {35'b0, tx_load}, 36'h1);
    repeat (2) @(posedge clk);
    dummies(3);
    check("t2_busy_mid", {35'b0, busy}, 36'h1);
    dummies(1);
    check("t2_busy_end", {35'b0, busy}, 36'h0);

    // Overrun frame during COMMIT is dropped
    wq.push_back({4'd3, 32'hA5C31E07});
    send(8'h07, 2); send(8'h07, 2); send(8'h1E, 2); send(8'hC3, 2);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'hA5;
    @(posedge clk); #1;
    rx_data = 8'h55;
    check("t3_commit", {35'b0, mem_we}, 36'h1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t3_err", err_pulses, 36'h1);
    check("t3_busy", {35'b0, busy}, 36'h0);
    expect_read(4'd3, 32'hA5C31E07);
    send(8'h06, 3);
    dummies(4);
    check("t3_busy_end", {35'b0, busy}, 36'h0);

    // Top address write and read
    wq.push_back({4'd15, 32'hDEADBEEF});
    send(8'h1F, 2); send(8'hEF, 2); send(8'hBE, 2); send(8'hAD, 2); send(8'hDE, 3);
    expect_read(4'd15, 32'hDEADBEEF);
    send(8'h1E, 2);
    dummies(4);
    check("t6_busy", {35'b0, busy}, 36'h0);

    // Idle after a write command
    send(8'h0F, 0);
    repeat (1100) @(posedge clk); #1;
`ifdef SPI_MEM_TIMEOUT_EN
    check("t4_busy", {35'b0, busy}, 36'h0);
    check("t4_err", err_pulses, 36'h2);
`else
    check("t4_busy", {35'b0, busy}, 36'h1);
    check("t4_err", err_pulses, 36'h1);
`endif
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Reset in the middle of a write
    send(8'h07, 2); send(8'h11, 2); send(8'h22, 2);
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("t5_wdata", {4'b0, mem_wdata}, 36'h0);
    check("t5_addr", {32'b0, mem_addr}, 36'h0);
    check("t5_busy", {35'b0, busy}, 36'h0);
    check("t5_tx", {28'b0, tx_data}, 36'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    expect_read(4'd3, 32'h44332211);
    send(8'h06, 2);
    dummies(4);
    check("t5_busy_end", {35'b0, busy}, 36'h0);
    repeat (3) @(posedge clk); #1;

`ifdef SPI_MEM_TIMEOUT_EN
    check("final_err", err_pulses, 36'h2);
`else
    check("final_err", err_pulses, 36'h1);
`endif
    check("wq_empty", wq.size(), 36'h0);
    check("rq_empty", rq.size(), 36'h0);
    check("tq_empty", tq.size(), 36'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
